// File: rtl/fsm_st_decoder.sv
// fsm_st_decoder: watches the state code of an fsm_* kernel and rebuilds
// the x->y transition events from it as registered one-hot pulses.
// It also measures how long each state was held and flags transitions that
// ALLOWED does not permit and state codes outside 0..NS-1.
// Optional feature: define FSM_DEC_HIST_EN to keep a 4-deep history of
// {from,to} pairs. Without it, hist and hist_cnt are tied to zero.
module fsm_st_decoder #(
    parameter int               SW      = 2,
    parameter int               NS      = 4,
    parameter logic [NS*NS-1:0] ALLOWED = '1,
    parameter int               CW      = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [SW-1:0]       st,
    input  logic                clr_err,
    output logic [SW-1:0]       cur_st,
    output logic [NS*NS-1:0]    ev,
    output logic                ev_vld,
    output logic [CW-1:0]       ev_dwell,
    output logic [CW-1:0]       dwell,
    output logic                illegal,
    output logic                range_err,
    output logic                err_sticky,
    output logic [4*2*SW-1:0]   hist,
    output logic [2:0]          hist_cnt
);

    localparam int            EW      = NS * NS;
    localparam int            HW      = 4 * 2 * SW;
    localparam logic [SW:0]   NS_CODE = (SW + 1)'(NS);

    // IDLE: nothing accepted yet, so there is no state to depart from.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [SW-1:0]    cur_st_d;
    logic [CW-1:0]    dwell_d;
    logic [EW-1:0]    ev_d;
    logic             ev_vld_d;
    logic [CW-1:0]    ev_dwell_d;
    logic             illegal_d;
    logic             range_err_d;
    logic             err_sticky_d;
    logic             in_range;
    logic [EW-1:0]    hot;
    int               ev_idx;

    // Dwell counter increment that sticks at the all-ones value.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == {CW{1'b1}}) ? v : v + CW'(1);
    endfunction

    // One-hot position of the candidate transition cur_st -> st.
    always_comb begin
        hot    = '0;
        ev_idx = int'(cur_st) * NS + int'(st);
        for (int i = 0; i < EW; i++) begin
            hot[i] = (i == ev_idx);
        end
    end

    // Next state, tracked state code, dwell and pulse outputs.
    always_comb begin
        state_d     = state_q;
        cur_st_d    = cur_st;
        dwell_d     = dwell;
        ev_d        = '0;
        ev_vld_d    = 1'b0;
        ev_dwell_d  = ev_dwell;
        illegal_d   = 1'b0;
        range_err_d = 1'b0;
        in_range    = ({1'b0, st} < NS_CODE);

        if (en) begin
            if (!in_range) begin
                // Out-of-range codes are reported and otherwise ignored.
                range_err_d = 1'b1;
            end else begin
                case (state_q)
                    IDLE: begin
                        cur_st_d = st;
                        dwell_d  = CW'(1);
                        state_d  = RUN;
                    end
                    RUN: begin
                        if (st == cur_st) begin
                            dwell_d = sat_inc(dwell);
                        end else begin
                            // Illegal transitions are still reported and tracked.
                            ev_d       = hot;
                            ev_vld_d   = 1'b1;
                            ev_dwell_d = dwell;
                            illegal_d  = ~|(hot & ALLOWED);
                            cur_st_d   = st;
                            dwell_d    = CW'(1);
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
        end

        // A new error wins over a simultaneous clear.
        if (illegal_d || range_err_d) begin
            err_sticky_d = 1'b1;
        end else if (clr_err) begin
            err_sticky_d = 1'b0;
        end else begin
            err_sticky_d = err_sticky;
        end
    end

    // State register and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cur_st     <= '0;
            dwell      <= '0;
            ev         <= '0;
            ev_vld     <= 1'b0;
            ev_dwell   <= '0;
            illegal    <= 1'b0;
            range_err  <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_st     <= cur_st_d;
            dwell      <= dwell_d;
            ev         <= ev_d;
            ev_vld     <= ev_vld_d;
            ev_dwell   <= ev_dwell_d;
            illegal    <= illegal_d;
            range_err  <= range_err_d;
            err_sticky <= err_sticky_d;
        end
    end

`ifdef FSM_DEC_HIST_EN
    logic [HW-1:0] hist_d;
    logic [2:0]    hist_cnt_d;

    // Push the new {from,to} pair into entry 0 on every event.
    always_comb begin
        hist_d     = hist;
        hist_cnt_d = hist_cnt;
        if (ev_vld_d) begin
            hist_d = {hist[HW-2*SW-1:0], cur_st, st};
            if (hist_cnt != 3'd4) begin
                hist_cnt_d = hist_cnt + 3'd1;
            end
        end
    end

    // History registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist     <= '0;
            hist_cnt <= '0;
        end else begin
            hist     <= hist_d;
            hist_cnt <= hist_cnt_d;
        end
    end
`else
    assign hist     = '0;
    assign hist_cnt = '0;
`endif

endmodule

// File: tb/tb_fsm_st_decoder.sv
// Testbench for fsm_st_decoder: directed scenarios followed by random
// samples, all compared against a behavioural model kept in this file.
module tb_fsm_st_decoder;

    localparam int SW = 3;
    localparam int NS = 5;
    localparam int CW = 4;
    localparam int EW = NS * NS;
    localparam int HW = 4 * 2 * SW;
    // 1->3 (bit 8) and 0->4 (bit 4) are not allowed.
    localparam logic [EW-1:0] ALW = ~((25'd1 << 8) | (25'd1 << 4));

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [SW-1:0] st;
    logic          clr_err;
    logic [SW-1:0] cur_st;
    logic [EW-1:0] ev;
    logic          ev_vld;
    logic [CW-1:0] ev_dwell;
    logic [CW-1:0] dwell;
    logic          illegal;
    logic          range_err;
    logic          err_sticky;
    logic [HW-1:0] hist;
    logic [2:0]    hist_cnt;

    int total = 0;
    int bad   = 0;

    // Reference model state
    bit              m_armed;
    int              m_cur;
    int              m_dwell;
    int              m_evd;
    bit              m_err;
    logic [EW-1:0]   x_ev;
    bit              x_vld;
    bit              x_ill;
    bit              x_rng;
    logic [2*SW-1:0] hq[$];

    fsm_st_decoder #(
        .SW(SW), .NS(NS), .ALLOWED(ALW), .CW(CW)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .st(st), .clr_err(clr_err),
        .cur_st(cur_st), .ev(ev), .ev_vld(ev_vld), .ev_dwell(ev_dwell),
        .dwell(dwell), .illegal(illegal), .range_err(range_err),
        .err_sticky(err_sticky), .hist(hist), .hist_cnt(hist_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_armed = 1'b0;
        m_cur   = 0;
        m_dwell = 0;
        m_evd   = 0;
        m_err   = 1'b0;
        x_ev    = '0;
        x_vld   = 1'b0;
        x_ill   = 1'b0;
        x_rng   = 1'b0;
        hq.delete();
    endtask

    // Applies the rules for one clock edge with the given sampled inputs.
    task automatic model_step(input bit e, input int s, input bit c);
        int idx;
        logic [SW-1:0] fc;
        logic [SW-1:0] tc;
        x_ev  = '0;
        x_vld = 1'b0;
        x_ill = 1'b0;
        x_rng = 1'b0;
        if (e) begin
            if (s >= NS) begin
                x_rng = 1'b1;
            end else if (!m_armed) begin
                m_armed = 1'b1;
                m_cur   = s;
                m_dwell = 1;
            end else if (s == m_cur) begin
                if (m_dwell < (1 << CW) - 1) m_dwell++;
            end else begin
                idx       = m_cur * NS + s;
                x_ev[idx] = 1'b1;
                x_vld     = 1'b1;
                x_ill     = !ALW[idx];
                m_evd     = m_dwell;
                fc        = SW'(m_cur);
                tc        = SW'(s);
                hq.push_front({fc, tc});
                if (hq.size() > 4) void'(hq.pop_back());
                m_cur   = s;
                m_dwell = 1;
            end
        end
        if (x_ill || x_rng) m_err = 1'b1;
        else if (c)         m_err = 1'b0;
    endtask

    task automatic check_all(input string tag);
        logic [HW-1:0] xh;
        int            xc;
        xh = '0;
        xc = 0;
`ifdef FSM_DEC_HIST_EN
        for (int i = 0; i < hq.size(); i++) xh[i*2*SW +: 2*SW] = hq[i];
        xc = hq.size();
`endif
        chk({tag, ".cur_st"},     64'(cur_st),     64'(m_cur));
        chk({tag, ".ev"},         64'(ev),         64'(x_ev));
        chk({tag, ".ev_vld"},     64'(ev_vld),     64'(x_vld));
        chk({tag, ".ev_dwell"},   64'(ev_dwell),   64'(m_evd));
        chk({tag, ".dwell"},      64'(dwell),      64'(m_dwell));
        chk({tag, ".illegal"},    64'(illegal),    64'(x_ill));
        chk({tag, ".range_err"},  64'(range_err),  64'(x_rng));
        chk({tag, ".err_sticky"}, 64'(err_sticky), 64'(m_err));
        chk({tag, ".hist"},       64'(hist),       64'(xh));
        chk({tag, ".hist_cnt"},   64'(hist_cnt),   64'(xc));
    endtask

    // Drive inputs just after an edge, let the next edge sample them, check.
    task automatic step(input bit e, input int s, input bit c, input string tag);
        en      = e;
        st      = SW'(s);
        clr_err = c;
        @(posedge clk);
        #1;
        model_step(e, s, c);
        check_all(tag);
    endtask

    task automatic do_reset(input bit async_chk);
        rst     = 1'b1;
        en      = 1'b0;
        st      = '0;
        clr_err = 1'b0;
        if (async_chk) begin
            #1;
            model_reset();
            check_all("async_rst");
        end
        @(posedge clk);
        #1;
        model_reset();
        check_all("reset");
        rst = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        en      = 1'b0;
        st      = '0;
        clr_err = 1'b0;
        model_reset();

        do_reset(1'b0);

        // Hold state 2: no events, dwell counts up.
        for (int i = 0; i < 5; i++) step(1'b1, 2, 1'b0, "hold2");
        chk("plan.dwell5", 64'(dwell), 64'd5);
        chk("plan.cur2", 64'(cur_st), 64'd2);

        // 2 -> 1 event carries the departed dwell.
        step(1'b1, 1, 1'b0, "ev21");
        chk("plan.ev21", 64'(ev), 64'(25'd1 << 11));
        chk("plan.ev_dwell5", 64'(ev_dwell), 64'd5);

        // 1 -> 3 is not allowed: event still issued, flagged.
        step(1'b1, 3, 1'b0, "ev13");
        chk("plan.illegal", 64'(illegal), 64'd1);
        chk("plan.ev13", 64'(ev), 64'(25'd1 << 8));
        step(1'b1, 3, 1'b1, "clr");
        chk("plan.cleared", 64'(err_sticky), 64'd0);

        // Out-of-range code is discarded.
        step(1'b1, 0, 1'b0, "ev30");
        step(1'b1, 6, 1'b0, "rng6");
        chk("plan.range", 64'(range_err), 64'd1);
        chk("plan.keep0", 64'(cur_st), 64'd0);
        step(1'b1, 0, 1'b0, "after_rng");
        chk("plan.no_ev", 64'(ev_vld), 64'd0);

        // Sampling disabled: everything frozen, no pulses.
        step(1'b0, 0, 1'b0, "en0a");
        step(1'b0, 1, 1'b0, "en0b");
        step(1'b0, 3, 1'b0, "en0c");
        step(1'b1, 3, 1'b0, "ev03");
        chk("plan.ev03", 64'(ev), 64'(25'd1 << 3));

        // History run 3->0->1->2->3->0->1.
        step(1'b1, 0, 1'b0, "h0");
        step(1'b1, 1, 1'b0, "h1");
        step(1'b1, 2, 1'b0, "h2");
        step(1'b1, 3, 1'b0, "h3");
        step(1'b1, 0, 1'b0, "h4");
        step(1'b1, 1, 1'b0, "h5");
`ifdef FSM_DEC_HIST_EN
        chk("plan.hist_cnt", 64'(hist_cnt), 64'd4);
        chk("plan.hist0", 64'(hist[5:0]), 64'(6'b000_001));
        chk("plan.hist3", 64'(hist[23:18]), 64'(6'b001_010));
`else
        chk("plan.hist_off", 64'(hist), 64'd0);
`endif

        // Error and clear together: error wins.
        step(1'b1, 7, 1'b1, "err_vs_clr");
        chk("plan.sticky_wins", 64'(err_sticky), 64'd1);

        // Dwell saturates at 2**CW-1.
        for (int i = 0; i < 20; i++) step(1'b1, 1, 1'b0, "sat");
        chk("plan.sat", 64'(dwell), 64'd15);
        step(1'b1, 4, 1'b0, "ev14");
        chk("plan.ev_dwell_sat", 64'(ev_dwell), 64'd15);

        // Reset mid-run; out-of-range while idle; first sample gives no event.
        do_reset(1'b1);
        step(1'b1, 5, 1'b0, "idle_rng");
        step(1'b1, 4, 1'b0, "first");
        chk("plan.first_no_ev", 64'(ev_vld), 64'd0);
        step(1'b1, 2, 1'b0, "ev42");

        // Random samples.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset($urandom_range(0, 1) == 1);
            end else begin
                step($urandom_range(0, 9) != 0, int'($urandom_range(0, 7)),
                     $urandom_range(0, 7) == 0, "rand");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
